// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake around a single full-subtractor cell.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             diffBit;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    assign diffBit  = aSh_q[0] ^ bSh_q[0] ^ borrow_q;
    assign borrow_d = (~aSh_q[0] & bSh_q[0]) | (~(aSh_q[0] ^ bSh_q[0]) & borrow_q);

    // New bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_single
            assign res_d = diffBit;
        end else begin : g_res_multi
            assign res_d = {diffBit, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aSh_q    <= '0;
            bSh_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        aSh_q    <= a;
                        bSh_q    <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    aSh_q    <= aSh_q >> 1;
                    bSh_q    <= bSh_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    // Final bit: publish the assembled word, including this edge's bit.
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= res_d;
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 4, 8 and 1, checked
// against plain integer arithmetic for the difference and borrow-out.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic       binIn;
    logic       start4, start8, start1;
    logic       busy4, done4, bout4;
    logic       busy8, done8, bout8;
    logic       busy1, done1, bout1;
    logic [3:0] diff4;
    logic [7:0] diff8;
    logic       diff1;

    int checks = 0;
    int errors = 0;
    int selW = 4;
    int doneCnt[3] = '{0, 0, 0};
    int opCnt[3] = '{0, 0, 0};
    logic [7:0] holdDiff[3];

    logic       curBusy, curDone, curBout;
    logic [7:0] curDiff;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(aIn[3:0]), .b(bIn[3:0]), .bin(binIn),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(aIn), .b(bIn), .bin(binIn),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(aIn[0]), .b(bIn[0]), .bin(binIn),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    // Route the outputs of whichever instance is under test to one set of wires.
    always_comb begin
        curBusy = busy4;
        curDone = done4;
        curBout = bout4;
        curDiff = {4'h0, diff4};
        case (selW)
            8: begin
                curBusy = busy8;
                curDone = done8;
                curBout = bout8;
                curDiff = diff8;
            end
            1: begin
                curBusy = busy1;
                curDone = done1;
                curBout = bout1;
                curDiff = {7'h0, diff1};
            end
            default: ;
        endcase
    end

    // Independent tally of done pulses, one per completed operation.
    always @(negedge clk) begin
        if (done4) doneCnt[0]++;
        if (done8) doneCnt[1]++;
        if (done1) doneCnt[2]++;
    end

    function automatic int widthIdx(input int w);
        return (w == 4) ? 0 : (w == 8) ? 1 : 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setStart(input int w, input logic v);
        case (w)
            8:       start8 = v;
            1:       start1 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic applyStimulus(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic binv, input bit disturb, input string tag);
        int         ix, cycles, busyCycles, ai, bi, di;
        logic [7:0] mask, expD;
        logic       expB;
        mask = (w == 8) ? 8'hFF : (w == 4) ? 8'h0F : 8'h01;
        ai   = int'(av & mask);
        bi   = int'(bv & mask);
        di   = ai - bi - int'(binv);
        expD = 8'(di) & mask;
        expB = (ai < bi + int'(binv));
        ix   = widthIdx(w);

        selW  = w;
        aIn   = av;
        bIn   = bv;
        binIn = binv;
        setStart(w, 1'b1);
        @(posedge clk); #1;
        setStart(w, 1'b0);
        checkOutput({tag, " busy after accept"}, 32'(curBusy), 32'd1);
        checkOutput({tag, " diff held in run"}, 32'(curDiff), 32'(holdDiff[ix]));

        cycles = 0;
        busyCycles = 0;
        while (!curDone && cycles < 40) begin
            if (curBusy) busyCycles++;
            if (disturb && cycles == 1) begin
                aIn = 8'd1;
                bIn = 8'd7;
                setStart(w, 1'b1);
            end
            if (disturb && cycles == 2) setStart(w, 1'b0);
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(w));
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(w));
        checkOutput({tag, " busy at done"}, 32'(curBusy), 32'd0);
        checkOutput({tag, " diff"}, 32'(curDiff), 32'(expD));
        checkOutput({tag, " bout"}, 32'(curBout), 32'(expB));
        holdDiff[ix] = expD;
        opCnt[ix]++;

        @(posedge clk); #1;
        checkOutput({tag, " done one cycle"}, 32'(curDone), 32'd0);
        checkOutput({tag, " diff held idle"}, 32'(curDiff), 32'(expD));
    endtask

    initial begin
        int         cycles;
        logic [7:0] ra, rb;
        logic       rbin;

        rst_n  = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        aIn    = '0;
        bIn    = '0;
        binIn  = 1'b0;
        holdDiff = '{8'h0, 8'h0, 8'h0};
        #12;
        checkOutput("reset busy", 32'({busy4, busy8, busy1}), 32'd0);
        checkOutput("reset done", 32'({done4, done8, done1}), 32'd0);
        checkOutput("reset diff", 32'({diff4, diff8, diff1}), 32'd0);
        checkOutput("reset bout", 32'({bout4, bout8, bout1}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(4, 8'd9,  8'd3,  1'b0, 1'b0, "w4 9-3");
        applyStimulus(4, 8'd3,  8'd9,  1'b0, 1'b0, "w4 3-9");
        applyStimulus(4, 8'd0,  8'd0,  1'b1, 1'b0, "w4 0-0-1");
        applyStimulus(4, 8'd15, 8'd15, 1'b1, 1'b0, "w4 15-15-1");
        applyStimulus(4, 8'd15, 8'd0,  1'b0, 1'b0, "w4 15-0");
        applyStimulus(4, 8'd9,  8'd3,  1'b0, 1'b1, "w4 disturbed");
        repeat (3) @(posedge clk);
        #1 checkOutput("w4 diff holds after idle", 32'(diff4), 32'd6);

        // Abort an operation two cycles into RUN.
        selW  = 4;
        aIn   = 8'd9;
        bIn   = 8'd3;
        binIn = 1'b0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(busy4), 32'd0);
        checkOutput("abort done", 32'(done4), 32'd0);
        checkOutput("abort diff", 32'(diff4), 32'd0);
        checkOutput("abort bout", 32'(bout4), 32'd0);
        holdDiff = '{8'h0, 8'h0, 8'h0};
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            checkOutput("abort no done", 32'(done4), 32'd0);
        end
        applyStimulus(4, 8'd5, 8'd2, 1'b0, 1'b0, "w4 after abort");

        // start held high: back-to-back operations spaced WIDTH+2 edges apart.
        aIn   = 8'd6;
        bIn   = 8'd2;
        binIn = 1'b0;
        start4 = 1'b1;
        cycles = 0;
        while (!done4 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("held start first done", 32'(done4), 32'd1);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!done4 && cycles < 40);
        start4 = 1'b0;
        checkOutput("held start spacing", 32'(cycles), 32'd6);
        checkOutput("held start diff", 32'(diff4), 32'd4);
        opCnt[0] += 2;
        holdDiff[0] = 8'd4;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom_range(0, 15));
            rb   = 8'($urandom_range(0, 15));
            rbin = 1'($urandom_range(0, 1));
            applyStimulus(4, ra, rb, rbin, 1'b0, "w4 random");
        end

        applyStimulus(8, 8'd0,   8'd0,   1'b0, 1'b0, "w8 0-0");
        applyStimulus(8, 8'd0,   8'd0,   1'b1, 1'b0, "w8 0-0-1");
        applyStimulus(8, 8'd255, 8'd255, 1'b1, 1'b0, "w8 255-255-1");
        applyStimulus(8, 8'd255, 8'd0,   1'b0, 1'b0, "w8 255-0");
        applyStimulus(8, 8'd0,   8'd255, 1'b1, 1'b0, "w8 0-255-1");
        applyStimulus(8, 8'd128, 8'd127, 1'b1, 1'b0, "w8 128-127-1");
        for (int i = 0; i < 200; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom_range(0, 1));
            applyStimulus(8, ra, rb, rbin, 1'b0, "w8 random");
        end

        applyStimulus(1, 8'd0, 8'd1, 1'b0, 1'b0, "w1 0-1");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'(i & 1), 8'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0, "w1 sweep");
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("w4 done count", 32'(doneCnt[0]), 32'(opCnt[0]));
        checkOutput("w8 done count", 32'(doneCnt[1]), 32'(opCnt[1]));
        checkOutput("w1 done count", 32'(doneCnt[2]), 32'(opCnt[2]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
